opr1_sequencer: RTL and testbench

//  Sequences PDP-8 Group 1 operate microinstructions (CLA/CLL, CMA/CML, IAC, RAR/RAL/BSW) over the

---
 rtl/opr1_sequencer.sv | 168 ++++++++++++++++
 tb/tb_opr1_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/opr1_sequencer.sv
// ============================================================================
//  Module      : opr1_sequencer
//  Description : Steps PDP-8 Group 1 operate microinstructions (CLA/CLL,
//                CMA/CML, IAC, RAR/RAL/BSW) through a clear/OR/invert
//                datapath in architectural event order, one event per clock.
//  Ports       : clk      in   system clock, rising edge
//                reset    in   asynchronous active-high reset
//                start    in   request, sampled only in IDLE
//                ir       in   12-bit instruction word
//                ac_in    in   12-bit accumulator operand (latched on start)
//                l_in     in   link operand (latched on start)
//                clr_ctl  out  clear control, high in E1 when CLA
//                inv_ctl  out  invert control, high in E2 when CMA
//                busy     out  high in every state except IDLE
//                done     out  one-cycle pulse in FIN, results valid
//                ac_out   out  working accumulator
//                l_out    out  working link
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module opr1_sequencer #(
  parameter int ENABLE_BSW = 1,
  parameter int COMPACT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] ir,
  input  logic [11:0] ac_in,
  input  logic        l_in,
  output logic        clr_ctl,
  output logic        inv_ctl,
  output logic        busy,
  output logic        done,
  output logic [11:0] ac_out,
  output logic        l_out
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_e1   = 3'd1;
  localparam logic [2:0] c_st_e2   = 3'd2;
  localparam logic [2:0] c_st_e3   = 3'd3;
  localparam logic [2:0] c_st_r1   = 3'd4;
  localparam logic [2:0] c_st_r2   = 3'd5;
  localparam logic [2:0] c_st_fin  = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [7:0]  r_ir;     // only the microinstruction bits are needed after decode
  logic [11:0] r_ac;
  logic        r_l;
  logic [11:0] w_cloi;
  logic        w_group1;

  // Successor of state s for microinstruction bits b. In COMPACT mode event
  // states whose bits are all zero are skipped; the rotate phase is entered
  // for exactly one of RAR/RAL, or for a lone IR[1] when byte swap exists.
  function automatic logic [2:0] f_next(input logic [2:0] s, input logic [7:0] b);
    logic w_e1;
    logic w_e2;
    logic w_e3;
    logic w_rot;
    logic w_twice;
    w_e1    = (COMPACT == 0) || b[7] || b[6];
    w_e2    = (COMPACT == 0) || b[5] || b[4];
    w_e3    = (COMPACT == 0) || b[0];
    w_rot   = (b[3] ^ b[2]) || (b[1] && !b[3] && !b[2] && (ENABLE_BSW != 0));
    w_twice = b[1] && (b[3] ^ b[2]);
    f_next  = c_st_fin;
    case (s)
      c_st_idle: begin
        if (w_e1)       f_next = c_st_e1;
        else if (w_e2)  f_next = c_st_e2;
        else if (w_e3)  f_next = c_st_e3;
        else if (w_rot) f_next = c_st_r1;
        else            f_next = c_st_fin;
      end
      c_st_e1: begin
        if (w_e2)       f_next = c_st_e2;
        else if (w_e3)  f_next = c_st_e3;
        else if (w_rot) f_next = c_st_r1;
        else            f_next = c_st_fin;
      end
      c_st_e2: begin
        if (w_e3)       f_next = c_st_e3;
        else if (w_rot) f_next = c_st_r1;
        else            f_next = c_st_fin;
      end
      c_st_e3:  f_next = w_rot ? c_st_r1 : c_st_fin;
      c_st_r1:  f_next = w_twice ? c_st_r2 : c_st_fin;
      default:  f_next = c_st_fin;
    endcase
  endfunction

  // One rotate step on {L,AC}. rar/ral both set never reaches this path.
  function automatic logic [12:0] f_rot(input logic [12:0] v, input logic rar,
                                        input logic ral);
    if (ral && !rar)      f_rot = {v[11:0], v[12]};
    else if (rar && !ral) f_rot = {v[0], v[12:1]};
    else                  f_rot = {v[12], v[5:0], v[11:6]};
  endfunction

  assign w_group1 = (ir[11:8] == 4'b1110);

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) w_next = w_group1 ? f_next(c_st_idle, ir[7:0]) : c_st_fin;
      end
      c_st_e1, c_st_e2, c_st_e3, c_st_r1: w_next = f_next(r_state, r_ir);
      c_st_r2:  w_next = c_st_fin;
      c_st_fin: w_next = c_st_idle;
      default:  w_next = c_st_idle;
    endcase
  end

  assign clr_ctl = (r_state == c_st_e1) && r_ir[7];
  assign inv_ctl = (r_state == c_st_e2) && r_ir[5];
  assign busy    = (r_state != c_st_idle);
  assign done    = (r_state == c_st_fin);
  assign ac_out  = r_ac;
  assign l_out   = r_l;

  // Shared clear/OR/invert path: clear then invert, only one is active per state.
  assign w_cloi = (clr_ctl ? 12'd0 : r_ac) ^ {12{inv_ctl}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_ir    <= 8'd0;
      r_ac    <= 12'd0;
      r_l     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_ir <= ir[7:0];
            r_ac <= ac_in;
            r_l  <= l_in;
          end
        end
        c_st_e1: begin
          r_ac <= w_cloi;
          if (r_ir[6]) r_l <= 1'b0;
        end
        c_st_e2: begin
          r_ac <= w_cloi;
          if (r_ir[4]) r_l <= ~r_l;
        end
        c_st_e3: begin
          // carry out of AC lands in L through the 13-bit add
          if (r_ir[0]) {r_l, r_ac} <= {r_l, r_ac} + 13'd1;
        end
        c_st_r1, c_st_r2: begin
          {r_l, r_ac} <= f_rot({r_l, r_ac}, r_ir[3], r_ir[2]);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_opr1_sequencer.sv
// ============================================================================
//  Module      : tb_opr1_sequencer
//  Description : Self-checking bench for opr1_sequencer. Three instances
//                (default, ENABLE_BSW=0, COMPACT=1) share stimulus; expected
//                results are queued per instance when an operation is
//                launched and popped when that instance pulses done.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_opr1_sequencer;

  typedef struct {
    logic [11:0] ac;
    logic        l;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] ir;
  logic [11:0] ac_in;
  logic        l_in;

  logic        clr_v  [3];
  logic        inv_v  [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic [11:0] ac_v   [3];
  logic        l_v    [3];

  int errors = 0;
  int checks = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t last_exp [3];

  opr1_sequencer #(.ENABLE_BSW(1), .COMPACT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .ac_in(ac_in), .l_in(l_in),
    .clr_ctl(clr_v[0]), .inv_ctl(inv_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .ac_out(ac_v[0]), .l_out(l_v[0]));

  opr1_sequencer #(.ENABLE_BSW(0), .COMPACT(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .ac_in(ac_in), .l_in(l_in),
    .clr_ctl(clr_v[1]), .inv_ctl(inv_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .ac_out(ac_v[1]), .l_out(l_v[1]));

  opr1_sequencer #(.ENABLE_BSW(1), .COMPACT(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .ac_in(ac_in), .l_in(l_in),
    .clr_ctl(clr_v[2]), .inv_ctl(inv_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .ac_out(ac_v[2]), .l_out(l_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one operation: result and DONE cycle after start.
  function automatic exp_t model(input logic [11:0] op, input logic [11:0] a,
                                 input logic li, input int bsw, input int cmp);
    exp_t        e;
    logic [12:0] v;
    int          n;
    int          rc;
    v = {li, a};
    n = 0;
    rc = 0;
    if (op[11:8] != 4'b1110) begin
      e.ac = a; e.l = li; e.lat = 1;
      return e;
    end
    if (cmp == 0 || op[7] || op[6]) n++;
    if (op[7]) v[11:0] = 12'd0;
    if (op[6]) v[12] = 1'b0;
    if (cmp == 0 || op[5] || op[4]) n++;
    if (op[5]) v[11:0] = ~v[11:0];
    if (op[4]) v[12] = ~v[12];
    if (cmp == 0 || op[0]) n++;
    if (op[0]) v = v + 13'd1;
    if (op[3] ^ op[2])                                  rc = op[1] ? 2 : 1;
    else if (op[1] && !op[3] && !op[2] && bsw != 0)     rc = 1;
    for (int i = 0; i < rc; i++) begin
      if (op[2])      v = {v[11:0], v[12]};
      else if (op[3]) v = {v[0], v[12:1]};
      else            v = {v[12], v[5:0], v[11:6]};
    end
    e.ac = v[11:0]; e.l = v[12]; e.lat = n + rc + 1;
    return e;
  endfunction

  task automatic check_done(input int d, input int k);
    exp_t e;
    int   sz;
    case (d)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    chk($sformatf("dut%0d_sb_nonempty", d), (sz > 0), 1);
    if (sz > 0) begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      last_exp[d] = e;
      chk($sformatf("dut%0d_ac", d), ac_v[d], e.ac);
      chk($sformatf("dut%0d_l", d), l_v[d], e.l);
      chk($sformatf("dut%0d_latency", d), k, e.lat);
    end
  endtask

  // Launch one operation on all instances and collect their results.
  // glitch_k>0 re-pulses start with different operands in that cycle.
  task automatic run_op(input logic [11:0] op, input logic [11:0] a, input logic li,
                        input int glitch_k, output logic [7:0] clr_m,
                        output logic [7:0] inv_m);
    logic [2:0] seen;
    q0.push_back(model(op, a, li, 1, 0));
    q1.push_back(model(op, a, li, 0, 0));
    q2.push_back(model(op, a, li, 1, 1));
    @(negedge clk);
    start = 1'b1; ir = op; ac_in = a; l_in = li;
    @(posedge clk);
    #1;
    start = 1'b0; ir = 12'o5000; ac_in = ~a; l_in = ~li;
    seen = 3'b000; clr_m = 8'd0; inv_m = 8'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      clr_m[k-1] = clr_v[0];
      inv_m[k-1] = inv_v[0];
      for (int d = 0; d < 3; d++) begin
        if (done_v[d] === 1'b1) begin
          if (seen[d]) chk($sformatf("dut%0d_extra_done", d), k, 0);
          else         check_done(d, k);
          seen[d] = 1'b1;
        end
      end
      if (k == glitch_k) begin
        start = 1'b1; ir = 12'o7200; ac_in = 12'o1111; l_in = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; ir = 12'o5000;
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d_done_seen", d), seen[d], 1'b1);
      if (seen[d]) begin
        chk($sformatf("dut%0d_ac_hold", d), ac_v[d], last_exp[d].ac);
        chk($sformatf("dut%0d_busy_idle", d), busy_v[d], 1'b0);
      end
    end
  endtask

  initial begin
    logic [7:0] cm;
    logic [7:0] im;
    logic       any_done;
    reset = 1'b1; start = 1'b0; ir = 12'd0; ac_in = 12'd0; l_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ac%0d", d), ac_v[d], 12'd0);
      chk($sformatf("rst_l%0d", d), l_v[d], 1'b0);
      chk($sformatf("rst_busy%0d", d), busy_v[d], 1'b0);
      chk($sformatf("rst_done%0d", d), done_v[d], 1'b0);
      chk($sformatf("rst_ctl%0d", d), {clr_v[d], inv_v[d]}, 2'b00);
    end

    run_op(12'o7001, 12'o7777, 1'b0, 0, cm, im);   // IAC wrap into L
    chk("iac_clr_mask", cm, 8'h00);
    chk("iac_inv_mask", im, 8'h00);
    run_op(12'o7041, 12'o0005, 1'b1, 0, cm, im);   // CIA
    chk("cia_clr_mask", cm, 8'h00);
    chk("cia_inv_mask", im, 8'h02);
    run_op(12'o7006, 12'o4000, 1'b0, 0, cm, im);   // RTL
    run_op(12'o7002, 12'o0077, 1'b0, 0, cm, im);   // BSW / no-op
    run_op(12'o7120, 12'o1234, 1'b0, 0, cm, im);   // CLL CML
    run_op(12'o5000, 12'o1234, 1'b1, 0, cm, im);   // not Group 1
    run_op(12'o7604, 12'o0321, 1'b0, 0, cm, im);   // IR[8] set: not Group 1
    run_op(12'o7010, 12'o1234, 1'b1, 0, cm, im);   // RAR
    run_op(12'o7012, 12'o0001, 1'b0, 0, cm, im);   // RTR
    run_op(12'o7016, 12'o4321, 1'b0, 0, cm, im);   // RAR+RAL: rotate skipped
    run_op(12'o7300, 12'o7777, 1'b1, 0, cm, im);   // CLA CLL
    chk("cla_clr_mask", cm, 8'h01);
    chk("cla_inv_mask", im, 8'h00);
    run_op(12'o7340, 12'o1357, 1'b1, 0, cm, im);   // CLA CLL CMA
    run_op(12'o7041, 12'o0005, 1'b1, 2, cm, im);   // start pulsed mid-sequence

    // Reset in E2 aborts the sequence without a done pulse.
    @(negedge clk);
    start = 1'b1; ir = 12'o7041; ac_in = 12'o0005; l_in = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_inv_e2", inv_v[0], 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_ac", ac_v[0], 12'd0);
    chk("midrst_l", l_v[0], 1'b0);
    chk("midrst_busy", busy_v[0], 1'b0);
    chk("midrst_done", done_v[0], 1'b0);
    chk("midrst_inv", inv_v[0], 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    any_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || done_v[1] === 1'b1 || done_v[2] === 1'b1) any_done = 1'b1;
    end
    chk("no_done_after_reset", any_done, 1'b0);
    chk("sb_drained", q0.size() + q1.size() + q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
